// File: rtl/mems_spi_pkg.sv
// Shared SPI definitions for the MEMS receiver and transmitter.
// Word width default, FSM state encodings and idle pin levels.
package mems_spi_pkg;

  localparam int DATA_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/mems_spi_rx_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulse on the synced value.
// Pulses are one clk wide and derived only from synchronized samples.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Next values: shift the raw pin in, remember last synced level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and history flops reset to the pin's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_LVL}};
      prev_q <= IDLE_LVL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/mems_spi_rx.sv
// SPI slave receiver for MEMS sensor words, MSB first, sampled on sck fall.
// Define MEMS_SPI_RX_MISO_EN to add the tx_data/miso return path.
module mems_spi_rx
  import mems_spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              CS,
`ifdef MEMS_SPI_RX_MISO_EN
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              new_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  logic sck_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_s;
  logic cs_rise;
  logic cs_fall;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .IDLE_LVL(SCK_IDLE)
  ) u_sck_sync (
    .clk (clk),
    .rst (rst),
    .d   (sck),
    .q   (sck_s),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .IDLE_LVL(CS_IDLE)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d   (CS),
    .q   (cs_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] mosi_d;
  logic                   mosi_s;

  state_e            state_q;
  state_e            state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              overrun_q;
  logic              overrun_d;
  logic              new_data_q;
  logic              new_data_d;
  logic              frame_err_q;
  logic              frame_err_d;

`ifdef MEMS_SPI_RX_MISO_EN
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] tx_d;
`else
  logic              unused_sync;
  assign unused_sync = cs_s ^ sck_rise ^ sck_s;
`endif

  // mosi shares the same depth so it lines up with the sck edge pulse.
  always_comb begin
    mosi_d = {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Frame FSM next-state; a CS rise always wins over a same-cycle sck edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    overrun_d   = overrun_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef MEMS_SPI_RX_MISO_EN
    tx_d        = tx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          cnt_d     = '0;
          shift_d   = '0;
          overrun_d = 1'b0;
`ifdef MEMS_SPI_RX_MISO_EN
          tx_d      = tx_data;
`endif
        end
      end
      RECV: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sck_fall) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d = HOLD;
          end
        end
`ifdef MEMS_SPI_RX_MISO_EN
        // First rise launches the MSB already on miso, so it must not shift.
        if (!cs_rise && sck_rise && cnt_q != '0) begin
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
`endif
      end
      HOLD: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (overrun_q) begin
            frame_err_d = 1'b1;
          end else begin
            data_d     = shift_q;
            new_data_d = 1'b1;
          end
        end else if (sck_fall) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All receiver state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_q      <= {SYNC_STAGES{MOSI_IDLE}};
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef MEMS_SPI_RX_MISO_EN
      tx_q        <= '0;
`endif
    end else begin
      mosi_q      <= mosi_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
`ifdef MEMS_SPI_RX_MISO_EN
      tx_q        <= tx_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

`ifdef MEMS_SPI_RX_MISO_EN
  assign miso = ~cs_s & tx_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_mems_spi_rx.sv
// Directed bench for mems_spi_rx: SPI master model at 16 clk per sck.
// Pulse monitor counts new_data/frame_err cycles and logs received words.
module tb_mems_spi_rx;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         mosi = 1'b0;
  logic         cs = 1'b1;
  logic [W-1:0] data_out;
  logic         new_data;
  logic         frame_err;
  logic         busy;
`ifdef MEMS_SPI_RX_MISO_EN
  logic [W-1:0] tx_data = '0;
  logic         miso;
  logic [W-1:0] miso_word;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int nd_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  logic [W-1:0] nd_vals [0:15];

  always #5 clk = ~clk;

  mems_spi_rx #(
    .DATA_W     (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .mosi     (mosi),
    .CS       (cs),
`ifdef MEMS_SPI_RX_MISO_EN
    .tx_data  (tx_data),
    .miso     (miso),
`endif
    .data_out (data_out),
    .new_data (new_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (new_data) begin
      if (nd_cnt < 16) nd_vals[nd_cnt] = data_out;
      nd_cnt++;
    end
    if (frame_err) fe_cnt++;
    if (new_data && frame_err) both_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = val[i];
      sck  = 1'b1;
      wait_clk(8);
`ifdef MEMS_SPI_RX_MISO_EN
      miso_word = {miso_word[W-2:0], miso};
`endif
      sck = 1'b0;
      wait_clk(8);
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits);
    cs = 1'b0;
    wait_clk(16);
    send_bits(val, nbits);
    wait_clk(8);
    cs = 1'b1;
  endtask

  initial begin
    wait_clk(5);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_nd", 32'(new_data), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clk(5);

    cs = 1'b0;
    wait_clk(6);
    check("busy_cs_low", 32'(busy), 32'h1);
    wait_clk(10);
    send_bits(32'hA5C3F0, 24);
    wait_clk(8);
    cs = 1'b1;
    wait_clk(10);
    check("f1_nd_cnt", 32'(nd_cnt), 32'd1);
    check("f1_word", 32'(nd_vals[0]), 32'hA5C3F0);
    check("f1_data", 32'(data_out), 32'hA5C3F0);
    check("f1_fe_cnt", 32'(fe_cnt), 32'd0);
    check("f1_busy", 32'(busy), 32'h0);

    send_frame(32'h000001, 24);
    wait_clk(8);
    send_frame(32'hFFFFFE, 24);
    wait_clk(10);
    check("b2b_nd_cnt", 32'(nd_cnt), 32'd3);
    check("b2b_w0", 32'(nd_vals[1]), 32'h000001);
    check("b2b_w1", 32'(nd_vals[2]), 32'hFFFFFE);

    send_frame(32'h7FFFFF, 23);
    wait_clk(10);
    check("short_fe_cnt", 32'(fe_cnt), 32'd1);
    check("short_nd_cnt", 32'(nd_cnt), 32'd3);
    check("short_data", 32'(data_out), 32'hFFFFFE);
    check("short_busy", 32'(busy), 32'h0);

    send_frame(32'h0ABCDEF, 25);
    wait_clk(10);
    check("over_fe_cnt", 32'(fe_cnt), 32'd2);
    check("over_nd_cnt", 32'(nd_cnt), 32'd3);
    check("over_data", 32'(data_out), 32'hFFFFFE);

    cs = 1'b0;
    wait_clk(6);
    cs = 1'b1;
    wait_clk(10);
    check("glitch_fe_cnt", 32'(fe_cnt), 32'd3);
    check("glitch_nd_cnt", 32'(nd_cnt), 32'd3);

    cs = 1'b0;
    wait_clk(16);
    send_bits(32'hFFF, 12);
    rst = 1'b1;
    cs  = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_nd", 32'(nd_cnt), 32'd3);
    send_frame(32'h123456, 24);
    wait_clk(10);
    check("post_rst_nd", 32'(nd_cnt), 32'd4);
    check("post_rst_word", 32'(nd_vals[3]), 32'h123456);
    check("post_rst_data", 32'(data_out), 32'h123456);
    check("post_rst_fe", 32'(fe_cnt), 32'd3);

`ifdef MEMS_SPI_RX_MISO_EN
    tx_data   = 24'h5A5A5A;
    miso_word = '0;
    send_frame(32'h3C3C3C, 24);
    wait_clk(10);
    check("miso_word", 32'(miso_word), 32'h5A5A5A);
    check("miso_rx", 32'(data_out), 32'h3C3C3C);
    check("miso_idle", 32'(miso), 32'h0);
`endif

    check("nd_fe_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mems_spi_rx.md
MEMS_SPI_RX -- requirements
Module: mems_spi_rx

Interface
REQ-001 Parameter DATA_W, default 24, shall set the received word width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, shall set the synchronizer flop depth on sck, mosi and CS (minimum 2).
REQ-003 clk  input  1  system clock; all sequential logic shall be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sck  input  1  SPI clock from master, idle low, asynchronous to clk.
REQ-006 mosi  input  1  serial data from master, MSB first, changes on sck rising edge.
REQ-007 CS  input  1  frame select, active-low, asynchronous to clk.
REQ-008 data_out  output  DATA_W  last complete received word.
REQ-009 new_data  output  1  one-cycle pulse when data_out updates.
REQ-010 frame_err  output  1  one-cycle pulse when a frame ends with a bit count other than DATA_W.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 sck, mosi and CS shall each pass through SYNC_STAGES flops before use; edges shall be detected on the synchronized values only.
REQ-013 The supported clk frequency shall be at least 4x the sck frequency; the master timing (16 clk per sck period) shall meet this with margin.
REQ-014 States: IDLE, RECV, HOLD.
REQ-015 IDLE -> RECV on synchronized CS falling edge; the bit counter and shift register shall clear in the same cycle.
REQ-016 In RECV, each synchronized sck falling edge shall shift synchronized mosi into the LSB (shift left) and increment the bit counter.
REQ-017 RECV -> HOLD when the counter reaches DATA_W; further sck falling edges in HOLD shall set an internal overrun flag and shall not shift.
REQ-018 On synchronized CS rising edge from HOLD with overrun clear: data_out shall load the shift register and new_data shall pulse in the next cycle; state -> IDLE.
REQ-019 On CS rising edge from RECV (short frame) or from HOLD with overrun set: data_out shall be unchanged, frame_err shall pulse in the next cycle, and new_data shall stay low; state -> IDLE.
REQ-020 A CS rising edge and an sck falling edge detected in the same cycle: the CS edge shall take priority and the sck edge shall be ignored.
REQ-021 new_data and frame_err shall never both be high, and each shall be exactly one cycle wide.
REQ-022 A glitch-free CS toggle with zero sck edges shall produce frame_err.

Reset
REQ-023 rst shall set state IDLE, counter 0, shift register 0, data_out 0, new_data 0, frame_err 0, overrun 0, and synchronizer flops to their idle values (sck 0, CS 1, mosi 0).
REQ-024 rst asserted mid-frame shall discard the partial word; the next frame shall be accepted only after a fresh CS falling edge.

Configuration
REQ-025 Macro MEMS_SPI_RX_MISO_EN: when defined, the module shall add input tx_data[DATA_W-1:0] and output miso, load tx_data on CS falling edge, drive its MSB, and shift left on each synchronized sck rising edge in RECV; miso shall be 0 while CS is high.
REQ-026 When the macro is undefined, neither port shall exist and the behaviour shall be otherwise identical.

Structure
REQ-027 The shared package mems_spi_pkg shall hold the DATA_W default, the state encodings (IDLE/RECV/HOLD), and the idle pin levels, shared with the transmitter.
REQ-028 One sub-module, spi_sync_edge (synchronizer plus rise/fall pulse), shall be instantiated once each for sck and CS; mosi shall use the synchronizer path only.

Verification
REQ-029 Master sends 24'hA5C3F0 at 16 clk per sck -> one new_data pulse, data_out = 24'hA5C3F0, frame_err 0.
REQ-030 Back-to-back frames 24'h000001 then 24'hFFFFFE with CS high for 8 clk between them -> two new_data pulses with the values in order.
REQ-031 CS released after 23 bits -> frame_err pulse, data_out keeps its prior value, busy low afterwards.
REQ-032 25 sck falling edges within one CS low -> frame_err pulse, no new_data.
REQ-033 rst asserted after 12 bits, then a full 24'h123456 frame -> data_out = 24'h123456 and exactly one new_data pulse.
REQ-034 With MEMS_SPI_RX_MISO_EN and tx_data = 24'h5A5A5A -> the miso bit sequence equals 24'h5A5A5A MSB first, while the received word is still correct.
